// File: rtl/nco_pkg.sv
// Shared types and helpers for the NCO output path: serializer FSM encoding
// and the two's-complement to offset-binary conversion.
package nco_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } nco_state_e;

    localparam int unsigned NCO_MAX_W = 64;

    // Inverting the sign bit maps the signed range onto 0..2^W-1 for the DAC.
    function automatic logic [NCO_MAX_W-1:0] to_offset_binary(
        input logic [NCO_MAX_W-1:0] data,
        input int unsigned          width,
        input logic                 enable
    );
        logic [NCO_MAX_W-1:0] mask_v;
        mask_v = {{(NCO_MAX_W-1){1'b0}}, 1'b1} << (width - 32'd1);
        return enable ? (data ^ mask_v) : data;
    endfunction

endpackage

// File: rtl/sclk_divider.sv
// Divides iclk into SCLK half-period ticks and classifies each tick as a
// rising or falling serial-clock edge once shifting is enabled.
module sclk_divider #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic iclk,
    input  logic iresetn,
    input  logic en,
    input  logic shift_en,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          phase_r;

    assign tick = en && (cnt_r == CW'(CLK_DIV - 32'd1));
    assign rise = tick && shift_en && !phase_r;
    assign fall = tick && shift_en && phase_r;

    // Half-period counter and SCLK phase; both restart whenever disabled.
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (!en) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else begin
            cnt_r <= tick ? '0 : (cnt_r + CW'(1));
            if (tick && shift_en) begin
                phase_r <= !phase_r;
            end
        end
    end

endmodule

// File: rtl/dac_serializer.sv
// Serializes NCO samples to an SPI-style DAC: frame select low, MSB first,
// data changing on falling SCLK edges, sticky overrun on rejected samples.
module dac_serializer
    import nco_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned CS_GAP        = 2,
    parameter int unsigned OFFSET_BINARY = 1
) (
    input  logic                  iclk,
    input  logic                  iresetn,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  ivalid,
    output logic                  oready,
    input  logic                  iclr_ovr,
    output logic                  osclk,
    output logic                  osdata,
    output logic                  ocs_n,
    output logic                  oovr
);

    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    nco_state_e            state_r;
    nco_state_e            state_nxt_s;
    logic [DATA_WIDTH-1:0] sreg_r;
    logic [DATA_WIDTH-1:0] sample_s;
    logic [BW-1:0]         bit_cnt_r;
    logic [GW-1:0]         gap_cnt_r;
    logic                  sclk_r;
    logic                  cs_n_r;
    logic                  ready_r;
    logic                  ovr_r;
    logic                  tick_s;
    logic                  rise_s;
    logic                  fall_s;
    logic                  accept_s;
    logic                  last_bit_s;
    logic                  gap_done_s;

    assign sample_s   = DATA_WIDTH'(to_offset_binary(NCO_MAX_W'(idata), DATA_WIDTH,
                                                     OFFSET_BINARY != 32'd0));
    assign accept_s   = (state_r == ST_IDLE) && ivalid;
    assign last_bit_s = fall_s && (bit_cnt_r == BW'(DATA_WIDTH - 32'd1));
    assign gap_done_s = (state_r == ST_GAP) && (gap_cnt_r == GW'(CS_GAP - 32'd1));

    sclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_divider (
        .iclk     (iclk),
        .iresetn  (iresetn),
        .en       ((state_r == ST_SETUP) || (state_r == ST_SHIFT)),
        .shift_en (state_r == ST_SHIFT),
        .tick     (tick_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    // Frame sequencing: accept, setup hold, bit shifting, inter-frame gap.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ivalid) state_nxt_s = ST_SETUP;
                else        state_nxt_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (tick_s) state_nxt_s = ST_SHIFT;
                else        state_nxt_s = ST_SETUP;
            end
            ST_SHIFT: begin
                if (last_bit_s) state_nxt_s = ST_GAP;
                else            state_nxt_s = ST_SHIFT;
            end
            ST_GAP: begin
                if (gap_done_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_GAP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and pin registers; the emptied shift register drives osdata low.
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            sreg_r    <= '0;
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
            sclk_r    <= 1'b0;
            cs_n_r    <= 1'b1;
            ready_r   <= 1'b1;
            ovr_r     <= 1'b0;
        end else begin
            ready_r <= (state_nxt_s == ST_IDLE);
            cs_n_r  <= !((state_nxt_s == ST_SETUP) || (state_nxt_s == ST_SHIFT));

            if (accept_s) begin
                sreg_r    <= sample_s;
                bit_cnt_r <= '0;
            end else if (fall_s) begin
                sreg_r    <= sreg_r << 1'b1;
                bit_cnt_r <= last_bit_s ? '0 : (bit_cnt_r + BW'(1));
            end

            if (rise_s) begin
                sclk_r <= 1'b1;
            end else if (fall_s || (state_r != ST_SHIFT)) begin
                sclk_r <= 1'b0;
            end

            if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_done_s ? '0 : (gap_cnt_r + GW'(1));
            end else begin
                gap_cnt_r <= '0;
            end

            // A new overrun takes priority over a simultaneous clear.
            if (ivalid && !ready_r) begin
                ovr_r <= 1'b1;
            end else if (iclr_ovr) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign oready = ready_r;
    assign osclk  = sclk_r;
    assign osdata = sreg_r[DATA_WIDTH-1];
    assign ocs_n  = cs_n_r;
    assign oovr   = ovr_r;

endmodule

// File: tb/tb_dac_serializer.sv
// Self-checking bench for dac_serializer: a pin-level DAC model rebuilds each
// frame from SCLK rising edges and is compared against arithmetic expectations.
module tb_dac_serializer;

    localparam int DW     = 16;
    localparam int CD     = 2;
    localparam int CG     = 2;
    localparam int CS_LOW = CD * (1 + 2 * DW);
    localparam int PERIOD = 1 + CS_LOW + CG;

    logic          iclk = 1'b0;
    logic          iresetn = 1'b0;
    logic [DW-1:0] idata = '0, idata2 = '0;
    logic          ivalid = 1'b0, ivalid2 = 1'b0;
    logic          iclr_ovr = 1'b0, iclr_ovr2 = 1'b0;
    logic          oready, osclk, osdata, ocs_n, oovr;
    logic          oready2, osclk2, osdata2, ocs_n2, oovr2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_q[$];
    logic [31:0] words_q[$], bits_q[$], low_q[$];
    logic [31:0] words2_q[$], bits2_q[$], low2_q[$];
    logic [31:0] mon_word, mon_bits, mon_low, mon2_word, mon2_bits, mon2_low;
    logic mon_sclk_p, mon_cs_p, mon2_sclk_p, mon2_cs_p;

    always #5 iclk = ~iclk;

    dac_serializer #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CS_GAP(CG), .OFFSET_BINARY(1)) u_dut (
        .iclk(iclk), .iresetn(iresetn), .idata(idata), .ivalid(ivalid), .oready(oready),
        .iclr_ovr(iclr_ovr), .osclk(osclk), .osdata(osdata), .ocs_n(ocs_n), .oovr(oovr)
    );

    dac_serializer #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CS_GAP(CG), .OFFSET_BINARY(0)) u_dut_raw (
        .iclk(iclk), .iresetn(iresetn), .idata(idata2), .ivalid(ivalid2), .oready(oready2),
        .iclr_ovr(iclr_ovr2), .osclk(osclk2), .osdata(osdata2), .ocs_n(ocs_n2), .oovr(oovr2)
    );

    // Accept log: a handshake completes on the edge where ivalid and oready are both high.
    always @(posedge iclk) begin
        cyc++;
        if (iresetn && ivalid && oready) acc_q.push_back(cyc);
    end

    // DAC model for the offset-binary instance: sample osdata on each SCLK rise.
    always @(negedge iclk) begin
        if (!iresetn) begin
            mon_word = 0; mon_bits = 0; mon_low = 0; mon_sclk_p = 1'b0; mon_cs_p = 1'b1;
        end else begin
            if (!ocs_n) begin
                mon_low++;
                if (osclk && !mon_sclk_p) begin
                    mon_word = (mon_word << 1) | 32'(osdata);
                    mon_bits++;
                end
            end
            if (ocs_n && !mon_cs_p) begin
                words_q.push_back(mon_word); bits_q.push_back(mon_bits); low_q.push_back(mon_low);
                mon_word = 0; mon_bits = 0; mon_low = 0;
            end
            mon_sclk_p = osclk; mon_cs_p = ocs_n;
        end
    end

    // DAC model for the pass-through instance.
    always @(negedge iclk) begin
        if (!iresetn) begin
            mon2_word = 0; mon2_bits = 0; mon2_low = 0; mon2_sclk_p = 1'b0; mon2_cs_p = 1'b1;
        end else begin
            if (!ocs_n2) begin
                mon2_low++;
                if (osclk2 && !mon2_sclk_p) begin
                    mon2_word = (mon2_word << 1) | 32'(osdata2);
                    mon2_bits++;
                end
            end
            if (ocs_n2 && !mon2_cs_p) begin
                words2_q.push_back(mon2_word); bits2_q.push_back(mon2_bits); low2_q.push_back(mon2_low);
                mon2_word = 0; mon2_bits = 0; mon2_low = 0;
            end
            mon2_sclk_p = osclk2; mon2_cs_p = ocs_n2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offset binary is the signed sample shifted up by half the code range.
    function automatic logic [31:0] model_word(input logic [31:0] d, input bit offset);
        if (offset) return (d + (32'd1 << (DW - 1))) % (32'd1 << DW);
        else        return d;
    endfunction

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        while (oready !== 1'b1 && n < 300) begin @(negedge iclk); n++; end
        if (n >= 300) check("send_ready", 32'(oready), 32'd1);
        idata = d; ivalid = 1'b1;
        @(negedge iclk);
        ivalid = 1'b0;
    endtask

    task automatic send_raw(input logic [DW-1:0] d);
        int n;
        n = 0;
        while (oready2 !== 1'b1 && n < 300) begin @(negedge iclk); n++; end
        if (n >= 300) check("send_raw_ready", 32'(oready2), 32'd1);
        idata2 = d; ivalid2 = 1'b1;
        @(negedge iclk);
        ivalid2 = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [DW-1:0] d, input bit raw);
        int n;
        logic [31:0] w, b, l;
        n = 0;
        while ((raw ? words2_q.size() : words_q.size()) == 0 && n < 400) begin
            @(negedge iclk); n++;
        end
        check({tag, "_frame_seen"}, 32'((raw ? words2_q.size() : words_q.size()) != 0), 32'd1);
        if ((raw ? words2_q.size() : words_q.size()) != 0) begin
            if (raw) begin w = words2_q.pop_front(); b = bits2_q.pop_front(); l = low2_q.pop_front(); end
            else     begin w = words_q.pop_front();  b = bits_q.pop_front();  l = low_q.pop_front();  end
            check({tag, "_word"}, w, model_word(32'(d), !raw));
            check({tag, "_edges"}, b, 32'(DW));
            check({tag, "_cs_low"}, l, 32'(CS_LOW));
        end
    endtask

    initial begin
        logic [DW-1:0] r;
        int n, busy;

        // Reset state, then the first clock after release.
        repeat (3) @(negedge iclk);
        check("rst_cs_n", 32'(ocs_n), 32'd1);
        check("rst_sclk", 32'(osclk), 32'd0);
        check("rst_sdata", 32'(osdata), 32'd0);
        check("rst_ovr", 32'(oovr), 32'd0);
        #2 iresetn = 1'b1;
        @(negedge iclk);
        check("rel_ready", 32'(oready), 32'd1);
        check("rel_cs_n", 32'(ocs_n), 32'd1);

        // Full-scale positive, then most-negative and zero back to back.
        send(16'h7FFF);
        check_frame("pos_full", 16'h7FFF, 1'b0);
        acc_q.delete();
        send(16'h8000);
        send(16'h0000);
        check_frame("neg_full", 16'h8000, 1'b0);
        check_frame("zero", 16'h0000, 1'b0);
        check("b2b_count", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() >= 2) check("b2b_period", 32'(acc_q[1] - acc_q[0]), 32'(PERIOD));
        check("b2b_no_ovr", 32'(oovr), 32'd0);

        for (int i = 0; i < 5; i++) begin
            r = DW'($urandom_range(0, (1 << DW) - 1));
            send(r);
            check_frame("rand", r, 1'b0);
        end

        // Pass-through instance.
        send_raw(16'h1234);
        check_frame("raw_1234", 16'h1234, 1'b1);
        for (int i = 0; i < 2; i++) begin
            r = DW'($urandom_range(0, (1 << DW) - 1));
            send_raw(r);
            check_frame("raw_rand", r, 1'b1);
        end

        // Continuous ivalid: throttled accepts, sticky overrun, set beats clear.
        acc_q.delete();
        r = DW'($urandom_range(0, (1 << DW) - 1));
        idata = r; ivalid = 1'b1;
        @(negedge iclk);
        check("ovr_before_reject", 32'(oovr), 32'd0);
        @(negedge iclk);
        check("ovr_after_reject", 32'(oovr), 32'd1);
        iclr_ovr = 1'b1;
        @(negedge iclk);
        iclr_ovr = 1'b0;
        check("ovr_set_wins", 32'(oovr), 32'd1);
        n = 0;
        while (acc_q.size() < 3 && n < 400) begin @(negedge iclk); n++; end
        ivalid = 1'b0;
        check("hold_accepts", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() >= 3) begin
            check("hold_period_1", 32'(acc_q[1] - acc_q[0]), 32'(PERIOD));
            check("hold_period_2", 32'(acc_q[2] - acc_q[1]), 32'(PERIOD));
        end
        for (int i = 0; i < 3; i++) check_frame("hold", r, 1'b0);
        check("ovr_sticky", 32'(oovr), 32'd1);
        iclr_ovr = 1'b1;
        @(negedge iclk);
        iclr_ovr = 1'b0;
        check("ovr_cleared", 32'(oovr), 32'd0);

        // Reset in the middle of a frame, with an overrun pending.
        r = DW'($urandom_range(0, (1 << DW) - 1));
        send(r);
        ivalid = 1'b1;
        @(negedge iclk);
        ivalid = 1'b0;
        n = 0;
        while (mon_bits < 7 && n < 200) begin @(negedge iclk); n++; end
        check("mid_frame_bits", mon_bits, 32'd7);
        #2 iresetn = 1'b0;
        #1;
        check("abort_cs_n", 32'(ocs_n), 32'd1);
        check("abort_sclk", 32'(osclk), 32'd0);
        check("abort_sdata", 32'(osdata), 32'd0);
        check("abort_ovr", 32'(oovr), 32'd0);
        @(negedge iclk);
        #2 iresetn = 1'b1;
        busy = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge iclk);
            if (!ocs_n || osclk || !oready) busy++;
        end
        check("post_abort_idle", 32'(busy), 32'd0);
        check("post_abort_frames", 32'(words_q.size()), 32'd0);
        r = DW'($urandom_range(0, (1 << DW) - 1));
        send(r);
        check_frame("post_abort", r, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
